// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to imem and
// buffers returned instructions for decode behind a valid/ready handshake.
//   state | meaning
//   IDLE  | one quiet cycle after reset release, no request issued
//   RUN   | issue requests while in-flight + buffered < DEPTH
//   DRAIN | no requests; absorbing stale responses left over from a redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_instr_d [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_pc_d    [DEPTH];
  logic [31:0]   pend_pc_q    [DEPTH];
  logic [31:0]   pend_pc_d    [DEPTH];

  logic req_fire, rsp_fire, push, pop;
  logic redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign imem_req_valid = (state_q == RUN) &&
                          (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign id_valid       = (count_q != '0);
  assign id_instr       = id_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign id_pc          = id_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign id_opcode      = id_instr[6:0];
  assign id_funct3      = id_instr[14:12];
  assign id_funct7      = id_instr[31:25];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
  assign pop      = id_valid && id_ready;
  assign push     = rsp_fire && (discard_q == '0) && !redirect_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    discard_d    = discard_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pend_wr_d    = pend_wr_q;
    pend_rd_d    = pend_rd_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    pend_pc_d    = pend_pc_q;

    if (state_q == IDLE) state_d = RUN;

    if (req_fire) begin
      pc_d                 = pc_q + 32'd4;
      pend_pc_d[pend_wr_q] = pc_q;
      pend_wr_d            = pend_wr_q + P_ONE;
    end

    if (req_fire && !rsp_fire)      inflight_d = inflight_q + C_ONE;
    else if (!req_fire && rsp_fire) inflight_d = inflight_q - C_ONE;

    // Every response retires its request's PC slot, stale or not.
    if (rsp_fire) begin
      pend_rd_d = pend_rd_q + P_ONE;
      if (discard_q != '0) begin
        discard_d = discard_q - C_ONE;
        if (discard_q == C_ONE && state_q == DRAIN) state_d = RUN;
      end
    end

    if (push) begin
      fifo_instr_d[wr_ptr_q] = imem_rsp_data;
      fifo_pc_d[wr_ptr_q]    = pend_pc_q[pend_rd_q];
      wr_ptr_d               = wr_ptr_q + P_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + P_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase

    // Redirect wins: anything still outstanding after this cycle is wrong-path.
    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      discard_d = inflight_d;
      state_d   = (inflight_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
        pend_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_wr_q    <= pend_wr_d;
      pend_rd_q    <= pend_rd_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a 1-cycle in-order instruction memory model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;

  int checks = 0;
  int failures = 0;
  logic        mem_en;
  logic [31:0] mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] id_pc_log[$];
  logic [31:0] id_instr_log[$];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
  );

  always #5 clk = ~clk;

  // Memory contents: addr 0 holds 0x002081B3, other words differ above the opcode.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0020_81B3 ^ {a[24:0], 7'b0};
  endfunction

  task automatic tick();
    logic rf, pf, idf;
    logic [31:0] ra, ipc, iin;
    #1;
    rf  = imem_req_valid & imem_req_ready;
    ra  = imem_req_addr;
    pf  = imem_rsp_valid;
    idf = id_valid & id_ready;
    ipc = id_pc;
    iin = id_instr;
    @(posedge clk);
    @(negedge clk);
    if (pf && mem_q.size() > 0) void'(mem_q.pop_front());
    if (rf) begin
      mem_q.push_back(ra);
      req_log.push_back(ra);
    end
    if (idf) begin
      id_pc_log.push_back(ipc);
      id_instr_log.push_back(iin);
    end
    redirect_valid = 1'b0;
    imem_rsp_valid = mem_en && (mem_q.size() > 0);
    imem_rsp_data  = imem_rsp_valid ? instr_of(mem_q[0]) : 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    mem_en         = 1'b0;
    mem_q.delete();
    req_log.delete();
    id_pc_log.delete();
    id_instr_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; mem_en = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_req: valid=%b addr=%h expected 0 00000000", imem_req_valid, imem_req_addr);
    end
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_id: valid=%b instr=%h pc=%h expected 0 0 0", id_valid, id_instr, id_pc);
    end
  endtask

  task automatic test_basic();
    do_reset();
    mem_en = 1'b1; id_ready = 1'b1;
    #1; checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL basic_idle: req_valid=%b expected 0", imem_req_valid);
    end
    tick();
    #1; checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL basic_first_req: valid=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr);
    end
    tick();
    #1; checks++;
    if (id_valid !== 1'b0) begin
      failures++; $display("FAIL basic_latency_early: id_valid=%b expected 0", id_valid);
    end
    tick();
    #1; checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_opcode !== 7'h33 ||
        id_funct3 !== 3'h0 || id_funct7 !== 7'h00) begin
      failures++;
      $display("FAIL basic_first_instr: valid=%b pc=%h op=%h f3=%h f7=%h expected 1 0 33 0 0",
               id_valid, id_pc, id_opcode, id_funct3, id_funct7);
    end
    repeat (10) tick();
    checks++;
    if (id_pc_log.size() < 3 || id_pc_log[0] !== 32'h0 || id_pc_log[1] !== 32'h4 ||
        id_pc_log[2] !== 32'h8) begin
      failures++;
      $display("FAIL basic_pc_order: n=%0d pcs=%h %h %h expected 0 4 8",
               id_pc_log.size(), id_pc_log[0], id_pc_log[1], id_pc_log[2]);
    end
    checks++;
    if (id_instr_log.size() < 3 || id_instr_log[0] !== 32'h0020_81B3 ||
        id_instr_log[1] !== 32'h0020_83B3 || id_instr_log[2] !== 32'h0020_85B3) begin
      failures++;
      $display("FAIL basic_instr: %h %h %h expected 002081b3 002083b3 002085b3",
               id_instr_log[0], id_instr_log[1], id_instr_log[2]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_en = 1'b1; id_ready = 1'b0;
    repeat (8) tick();
    #1; checks++;
    if (req_log.size() != 2 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit: reqs=%0d req_valid=%b expected 2 0", req_log.size(), imem_req_valid);
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0020_81B3) begin
      failures++;
      $display("FAIL bp_head: valid=%b pc=%h instr=%h expected 1 0 002081b3", id_valid, id_pc, id_instr);
    end
    repeat (3) tick();
    #1; checks++;
    if (id_instr !== 32'h0020_81B3 || req_log.size() != 2) begin
      failures++;
      $display("FAIL bp_hold: instr=%h reqs=%0d expected 002081b3 2", id_instr, req_log.size());
    end
    id_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (id_pc_log.size() < 3 || id_pc_log[0] !== 32'h0 || id_pc_log[1] !== 32'h4 ||
        id_pc_log[2] !== 32'h8) begin
      failures++;
      $display("FAIL bp_drain: n=%0d pcs=%h %h %h expected 0 4 8",
               id_pc_log.size(), id_pc_log[0], id_pc_log[1], id_pc_log[2]);
    end
    checks++;
    if (req_log.size() < 3 || req_log[2] !== 32'h8) begin
      failures++; $display("FAIL bp_resume: n=%0d req2=%h expected 8", req_log.size(), req_log[2]);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    mem_en = 1'b0; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    tick();
    tick();
    #1; checks++;
    if (req_log.size() != 2 || req_log[0] !== 32'h10 || req_log[1] !== 32'h14 ||
        imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_setup: n=%0d reqs=%h %h valid=%b expected 2 10 14 0",
               req_log.size(), req_log[0], req_log[1], imem_req_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100; mem_en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_quiet%0d: req_valid=%b id_valid=%b expected 0 0", i, imem_req_valid, id_valid);
      end
      tick();
    end
    #1; checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL drain_resume: valid=%b addr=%h expected 1 00000100", imem_req_valid, imem_req_addr);
    end
    repeat (6) tick();
    checks++;
    if (id_pc_log.size() < 1 || id_pc_log[0] !== 32'h100 || id_instr_log[0] !== 32'h0020_01B3) begin
      failures++;
      $display("FAIL drain_first_id: n=%0d pc=%h instr=%h expected 100 002001b3",
               id_pc_log.size(), id_pc_log[0], id_instr_log[0]);
    end
  endtask

  task automatic test_redirect_collision();
    do_reset();
    mem_en = 1'b1; id_ready = 1'b0;
    tick();
    tick();
    tick();
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1; checks++;
    if (id_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL coll_setup: id_valid=%b rsp_valid=%b expected 1 1", id_valid, imem_rsp_valid);
    end
    tick();
    #1; checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL coll_after: id_valid=%b req_valid=%b addr=%h expected 0 1 00000200",
               id_valid, imem_req_valid, imem_req_addr);
    end
    checks++;
    if (id_pc_log.size() != 1 || id_pc_log[0] !== 32'h0) begin
      failures++;
      $display("FAIL coll_consumed: n=%0d pc=%h expected 1 0", id_pc_log.size(), id_pc_log[0]);
    end
    repeat (6) tick();
    checks++;
    if (id_pc_log.size() < 2 || id_pc_log[1] !== 32'h200) begin
      failures++;
      $display("FAIL coll_next: n=%0d pc=%h expected 200", id_pc_log.size(), id_pc_log[1]);
    end
  endtask

  task automatic test_align_wrap();
    do_reset();
    mem_en = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0107;
    tick();
    #1; checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin
      failures++;
      $display("FAIL align: valid=%b addr=%h expected 1 00000104", imem_req_valid, imem_req_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    #1; checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL wrap_stale_drain: req_valid=%b expected 0", imem_req_valid);
    end
    tick();
    #1; checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_target: valid=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    repeat (8) tick();
    checks++;
    if (req_log.size() < 3 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_reqs: n=%0d req1=%h req2=%h expected fffffffc 0",
               req_log.size(), req_log[1], req_log[2]);
    end
    checks++;
    if (id_pc_log.size() < 2 || id_pc_log[0] !== 32'hFFFF_FFFC || id_pc_log[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_id: n=%0d pcs=%h %h expected fffffffc 0", id_pc_log.size(), id_pc_log[0], id_pc_log[1]);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    mem_en = 1'b0; id_ready = 1'b0;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    #1; rst_n = 1'b0; #1;
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: req_valid=%b id_valid=%b addr=%h expected 0 0 0",
               imem_req_valid, id_valid, imem_req_addr);
    end
    do_reset();
    mem_en = 1'b1; id_ready = 1'b1;
    #1; checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL mid_idle: req_valid=%b expected 0", imem_req_valid);
    end
    tick();
    #1; checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_restart: valid=%b addr=%h expected 1 0", imem_req_valid, imem_req_addr);
    end
    repeat (5) tick();
    checks++;
    if (id_pc_log.size() < 1 || id_pc_log[0] !== 32'h0) begin
      failures++;
      $display("FAIL mid_no_discard: n=%0d pc=%h expected 0", id_pc_log.size(), id_pc_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collision();
    test_align_wrap();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the control/decode unit. It owns the PC, issues in-order word requests to instruction memory, and buffers returned instructions in a small FIFO. It presents each instruction, its PC and the pre-sliced opcode/funct3/funct7 fields to decode over a valid/ready handshake. Branch and jump resolution redirects it through a single redirect port, which flushes all wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
DEPTH, 2, instruction FIFO entries and also the maximum in-flight requests; power of 2, ≥2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response data valid; responses return in request order, ≥1 cycle after acceptance
imem_rsp_data  input  32  fetched instruction word
redirect_valid  input  1  one-cycle pulse: change fetch stream
redirect_pc  input  32  new fetch target
id_valid  output  1  instruction available to decode
id_ready  input  1  decode accepts this cycle
id_instr  output  32  instruction at FIFO head
id_pc  output  32  PC of id_instr
id_opcode  output  7  id_instr[6:0]
id_funct3  output  3  id_instr[14:12]
id_funct7  output  7  id_instr[31:25]

Behaviour:
- Reset (asynchronous, while rst_n=0): pc=RESET_PC, FIFO empty, inflight=0, discard=0, state=IDLE. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- States:
  - IDLE: occupied for exactly one cycle after reset release, with no request issued. Transitions to RUN.
  - RUN: imem_req_valid=1 when (inflight + fifo_count) < DEPTH. Credit uses registered counts only; a pop in the same cycle does not count.
  - DRAIN: imem_req_valid=0. Entered on redirect when the resulting discard>0. Returns to RUN on the cycle the last stale response is absorbed (discard 1→0).
- Request accepted (valid & ready): pc←pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0), inflight+1. The PC of each request is queued alongside it for id_pc.
- Response (imem_rsp_valid=1), always inflight-1:
  - if discard>0: discard-1 and the data is dropped;
  - otherwise: push {data, pc} to the FIFO.
  - The credit rule guarantees the FIFO is never full on a push. A response arriving with inflight=0 is a protocol error; ignore it.
- Decode handshake: pop when id_valid & id_ready. id_* are combinational from the FIFO head, held stable while id_valid & !id_ready.
- Redirect (any state):
  - pc←{redirect_pc[31:2],2'b00}; FIFO flushed; id_valid=0 next cycle.
  - discard←inflight after that cycle's updates, i.e. it includes a request accepted and excludes a response received in the redirect cycle.
  - Next state: DRAIN if discard>0, else RUN.
- Simultaneous events in the redirect cycle:
  - decode handshake: the pop completes (decode consumed it), then the flush applies;
  - imem response: treated as stale and dropped;
  - request accepted: that request is counted stale;
  - redirect during DRAIN: discard recomputed from current inflight, stays in DRAIN.
- Latency: request accepted at cycle N with a response at N+k → id_valid at N+k+1.
- Reset mid-operation clears all counts and the FIFO immediately. The memory is reset by the same rst_n, so no stale responses are expected after reset.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory → first request addr 0x0000_0000 on 2nd cycle after release; with id_ready=1, addresses 0x0,0x4,0x8 appear on id_pc in order, and id_opcode=0x33 for instr 0x0020_81B3.
- id_ready=0, memory always ready → exactly 2 requests issued, then imem_req_valid=0; id_instr held stable. Raising id_ready drains both entries, then requests resume at 0x8.
- Two requests in flight (0x10,0x14), redirect_pc=0x100 → DRAIN. Both responses are dropped and id_valid never asserts for them. The next request is 0x100 and the next id_pc is 0x100.
- Redirect in the same cycle as an id handshake and an imem response → the handshaked instruction counts as consumed, the response is dropped, and the FIFO is empty the next cycle.
- redirect_pc=0x0000_0107 → next request addr 0x104. redirect_pc=0xFFFF_FFFC → requests 0xFFFF_FFFC then 0x0000_0000.
- Assert rst_n=0 mid-DRAIN → imem_req_valid and id_valid go 0 immediately. After release, fetch restarts at RESET_PC with discard=0.
